div_sqrt_mvp_arbiter: RTL

- Round-robin arbiter and sequencer that shares one div_sqrt_mvp_wrapper instance between NUM_REQ requesters (e.g. FPU lanes or cores).
- Registers the winning request, issues a one-cycle start pulse to the unit, and tracks the single in-flight owner.
- Captures the unit's result and flags into a one-entry buffer and returns them to the owner with valid/ready backpressure. Supports owner-initiated kill.

---
 rtl/div_sqrt_mvp_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/div_sqrt_mvp_arbiter.sv
// Round-robin arbiter/sequencer sharing one div_sqrt_mvp unit between NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining DIV_SQRT_ARB_TIMEOUT_EN.
module div_sqrt_mvp_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64,
  parameter int C_OP_FP64      = 64,
  parameter int C_RM           = 3,
  parameter int C_PC           = 6,
  parameter int C_FS           = 2
) (
  input  logic                           Clk_CI,
  input  logic                           Rst_RI,
  input  logic [NUM_REQ-1:0]             Req_SI,
  output logic [NUM_REQ-1:0]             Gnt_SO,
  input  logic [NUM_REQ-1:0]             Op_SI,
  input  logic [NUM_REQ*C_OP_FP64-1:0]   Operand_a_DI,
  input  logic [NUM_REQ*C_OP_FP64-1:0]   Operand_b_DI,
  input  logic [NUM_REQ*C_RM-1:0]        RM_SI,
  input  logic [NUM_REQ*C_PC-1:0]        Precision_ctl_SI,
  input  logic [NUM_REQ*C_FS-1:0]        Format_sel_SI,
  input  logic [NUM_REQ-1:0]             Kill_SI,
  output logic [NUM_REQ-1:0]             Resp_valid_SO,
  input  logic [NUM_REQ-1:0]             Resp_ready_SI,
  output logic [C_OP_FP64-1:0]           Result_DO,
  output logic [4:0]                     Fflags_SO,
  output logic                           Busy_SO,
  output logic                           Unit_div_start_SO,
  output logic                           Unit_sqrt_start_SO,
  output logic [C_OP_FP64-1:0]           Unit_operand_a_DO,
  output logic [C_OP_FP64-1:0]           Unit_operand_b_DO,
  output logic [C_RM-1:0]                Unit_rm_SO,
  output logic [C_PC-1:0]                Unit_precision_ctl_SO,
  output logic [C_FS-1:0]                Unit_format_sel_SO,
  output logic                           Unit_kill_SO,
  input  logic                           Unit_ready_SI,
  input  logic                           Unit_done_SI,
  input  logic [C_OP_FP64-1:0]           Unit_result_DI,
  input  logic [4:0]                     Unit_fflags_SI
);
  localparam int IDX_W = (ID_W > 0) ? ID_W : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d, owner_q, owner_d;
  logic                 div_start_q, div_start_d, sqrt_start_q, sqrt_start_d;
  logic                 kill_q, kill_d;
  logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [C_OP_FP64-1:0] op_a_q, op_a_d, op_b_q, op_b_d, result_q, result_d;
  logic [C_RM-1:0]      rm_q, rm_d;
  logic [C_PC-1:0]      pc_q, pc_d;
  logic [C_FS-1:0]      fs_q, fs_d;
  logic [4:0]           fflags_q, fflags_d;
  logic                 found, grant, owner_kill;
  logic [IDX_W-1:0]     winner, cand;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
  localparam int CNT_W = 16;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && Req_SI[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign grant      = (state_q == IDLE) && Unit_ready_SI && found;
  assign owner_kill = Kill_SI[owner_q];

  always_comb begin
    Gnt_SO = '0;
    if (grant) Gnt_SO[winner] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rm_d         = rm_q;
    pc_d         = pc_q;
    fs_d         = fs_q;
    result_d     = result_q;
    fflags_d     = fflags_q;
    resp_valid_d = resp_valid_q;
    div_start_d  = 1'b0;
    sqrt_start_d = 1'b0;
    kill_d       = 1'b0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant) begin
          owner_d      = winner;
          op_a_d       = Operand_a_DI[winner*C_OP_FP64 +: C_OP_FP64];
          op_b_d       = Operand_b_DI[winner*C_OP_FP64 +: C_OP_FP64];
          rm_d         = RM_SI[winner*C_RM +: C_RM];
          pc_d         = Precision_ctl_SI[winner*C_PC +: C_PC];
          fs_d         = Format_sel_SI[winner*C_FS +: C_FS];
          div_start_d  = ~Op_SI[winner];
          sqrt_start_d = Op_SI[winner];
          ptr_d        = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          state_d      = ISSUE;
        end
      end
      ISSUE: begin
        if (owner_kill) begin
          kill_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = BUSY;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUSY: begin
        // Kill outranks a coincident Done; Done outranks a coincident timeout.
        if (owner_kill) begin
          kill_d  = 1'b1;
          state_d = IDLE;
        end else if (Unit_done_SI) begin
          result_d              = Unit_result_DI;
          fflags_d              = Unit_fflags_SI;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = RESP;
        end
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          kill_d                = 1'b1;
          result_d              = '0;
          fflags_d              = 5'b10000;
          resp_valid_d[owner_q] = 1'b1;
          state_d               = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (owner_kill || Resp_ready_SI[owner_q]) begin
          resp_valid_d = '0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      owner_q      <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      rm_q         <= '0;
      pc_q         <= '0;
      fs_q         <= '0;
      result_q     <= '0;
      fflags_q     <= '0;
      resp_valid_q <= '0;
      div_start_q  <= 1'b0;
      sqrt_start_q <= 1'b0;
      kill_q       <= 1'b0;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      rm_q         <= rm_d;
      pc_q         <= pc_d;
      fs_q         <= fs_d;
      result_q     <= result_d;
      fflags_q     <= fflags_d;
      resp_valid_q <= resp_valid_d;
      div_start_q  <= div_start_d;
      sqrt_start_q <= sqrt_start_d;
      kill_q       <= kill_d;
`ifdef DIV_SQRT_ARB_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign Busy_SO               = (state_q != IDLE);
  assign Resp_valid_SO         = resp_valid_q;
  assign Result_DO             = result_q;
  assign Fflags_SO             = fflags_q;
  assign Unit_div_start_SO     = div_start_q;
  assign Unit_sqrt_start_SO    = sqrt_start_q;
  assign Unit_kill_SO          = kill_q;
  assign Unit_operand_a_DO     = op_a_q;
  assign Unit_operand_b_DO     = op_b_q;
  assign Unit_rm_SO            = rm_q;
  assign Unit_precision_ctl_SO = pc_q;
  assign Unit_format_sel_SO    = fs_q;

endmodule
